// File: rtl/sram22_pkg.sv
// sram22 macro configuration shared by the request controller.
// Defaults for the 256x32 macro with byte-lane write mask.
package sram22_pkg;

   localparam int SRAM_DATA_WIDTH = 32;
   localparam int SRAM_ADDR_WIDTH = 8;
   localparam int SRAM_RSP_DEPTH  = 2;

   // One write-mask bit per byte lane.
   function automatic int wmask_width(input int dw);
      return dw / 8;
   endfunction

   localparam int SRAM_WMASK_WIDTH = wmask_width(SRAM_DATA_WIDTH);

endpackage

// File: rtl/sram22_rsp_fifo.sv
// Response FIFO: holds read data returned by the macro until taken.
// First-word output, push/pop/count, synchronous reset.
module sram22_rsp_fifo #(
   parameter int DW    = 32,
   parameter int DEPTH = 2
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic [DW-1:0]              din_i,
   input  logic                       pop_i,
   output logic [DW-1:0]              dout_o,
   output logic                       valid_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign do_pop  = pop_i & (count_q != '0);
   assign dout_o  = mem_q[rd_ptr_q];
   assign valid_o = (count_q != '0);
   assign count_o = count_q;

   // Next pointers and occupancy; push and pop together keep count.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_i, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Data storage; a push during reset is dropped.
   always_ff @(posedge clk) begin
      if (!rst && push_i) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/sram22_req_ctrl.sv
// Request controller for one sram22 single-port macro.
// Credit-gated acceptance so returned read data always has a slot.
module sram22_req_ctrl
   import sram22_pkg::*;
#(
   parameter int DATA_WIDTH  = SRAM_DATA_WIDTH,
   parameter int ADDR_WIDTH  = SRAM_ADDR_WIDTH,
   parameter int WMASK_WIDTH = wmask_width(DATA_WIDTH),
   parameter int RSP_DEPTH   = SRAM_RSP_DEPTH
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_we,
   input  logic [WMASK_WIDTH-1:0] req_wmask,
   input  logic [ADDR_WIDTH-1:0]  req_addr,
   input  logic [DATA_WIDTH-1:0]  req_wdata,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DATA_WIDTH-1:0]  rsp_rdata,
   output logic                   sram_we,
   output logic [WMASK_WIDTH-1:0] sram_wmask,
   output logic [ADDR_WIDTH-1:0]  sram_addr,
   output logic [DATA_WIDTH-1:0]  sram_din,
   input  logic [DATA_WIDTH-1:0]  sram_dout
);

   localparam int CW = $clog2(RSP_DEPTH + 1);
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(RSP_DEPTH);

   logic          fire;
   logic          pop;
   logic          rd_pending_q, rd_pending_d;
   logic [CW-1:0] count;
   logic [CW:0]   occ;

   // Slots committed after this cycle: stored + in flight - leaving.
   always_comb begin
      occ = {1'b0, count}
          + {{CW{1'b0}}, rd_pending_q}
          - {{CW{1'b0}}, pop};
      req_ready    = !rst && (occ < DEPTH_C);
      fire         = req_valid & req_ready;
      pop          = rsp_valid & rsp_ready;
      rd_pending_d = fire & ~req_we;
   end

   // Macro is driven straight from the request; idle reads are harmless.
   assign sram_we    = fire & req_we;
   assign sram_wmask = req_wmask;
   assign sram_addr  = req_addr;
   assign sram_din   = req_wdata;

   // Marks the cycle in which the macro presents read data.
   always_ff @(posedge clk) begin
      if (rst) rd_pending_q <= 1'b0;
      else     rd_pending_q <= rd_pending_d;
   end

   sram22_rsp_fifo #(
      .DW    (DATA_WIDTH),
      .DEPTH (RSP_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (rd_pending_q),
      .din_i   (sram_dout),
      .pop_i   (pop),
      .dout_o  (rsp_rdata),
      .valid_o (rsp_valid),
      .count_o (count)
   );

endmodule

// File: tb/tb_sram22_req_ctrl.sv
// Bench for sram22_req_ctrl with a behavioural sram22 macro.
// Table vectors, directed corner sequences and random traffic.
module tb_sram22_req_ctrl;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [3:0]  req_wmask;
   logic [7:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        sram_we;
   logic [3:0]  sram_wmask;
   logic [7:0]  sram_addr;
   logic [31:0] sram_din;
   logic [31:0] sram_dout;

   always #5 clk = ~clk;

   sram22_req_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_wmask  (req_wmask),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .sram_we    (sram_we),
      .sram_wmask (sram_wmask),
      .sram_addr  (sram_addr),
      .sram_din   (sram_din),
      .sram_dout  (sram_dout)
   );

   // Macro model: masked write, 1-cycle read, junk on dout after a write.
   logic [31:0] macro_mem [256];
   always @(posedge clk) begin
      if (sram_we) begin
         for (int b = 0; b < 4; b++)
            if (sram_wmask[b]) macro_mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
         sram_dout <= $urandom;
      end else begin
         sram_dout <= macro_mem[sram_addr];
      end
   end

   int nchk = 0;
   int nerr = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: memory image plus queue of owed responses.
   typedef struct {
      logic [31:0] data;
      int          avail;
   } exp_t;

   logic [31:0] ref_mem [256];
   exp_t        exp_q [$];
   int          cyc  = 0;
   int          npop = 0;
   bit          m_valid, m_pop, m_fire, m_ready;

   // Observes each cycle mid-period and predicts every visible output.
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         chk("rst_ready", {31'b0, req_ready}, 32'd0);
         chk("rst_we", {31'b0, sram_we}, 32'd0);
         exp_q.delete();
      end else begin
         m_valid = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
         m_pop   = m_valid && rsp_ready;
         chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_valid});
         if (m_valid) chk("rsp_rdata", rsp_rdata, exp_q[0].data);
         m_ready = (exp_q.size() - (m_pop ? 1 : 0)) < DEPTH;
         chk("req_ready", {31'b0, req_ready}, {31'b0, m_ready});
         m_fire = req_valid && m_ready;
         chk("sram_we", {31'b0, sram_we}, {31'b0, m_fire && req_we});
         if (m_fire) begin
            chk("sram_addr", {24'b0, sram_addr}, {24'b0, req_addr});
            if (req_we) begin
               chk("sram_din", sram_din, req_wdata);
               chk("sram_wmask", {28'b0, sram_wmask}, {28'b0, req_wmask});
            end
         end
         if (m_pop) begin
            void'(exp_q.pop_front());
            npop++;
         end
         if (m_fire) begin
            if (req_we) begin
               for (int b = 0; b < 4; b++)
                  if (req_wmask[b]) ref_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
            end else begin
               exp_q.push_back('{data: ref_mem[req_addr], avail: cyc + 2});
            end
         end
      end
   end

   // Presents one request until accepted or the budget runs out.
   task automatic issue(input logic we, input logic [3:0] m, input logic [7:0] a,
                        input logic [31:0] d, input int budget, output bit ok);
      req_valid = 1'b1;
      req_we    = we;
      req_wmask = m;
      req_addr  = a;
      req_wdata = d;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (req_ready) ok = 1'b1;
         @(posedge clk);
         #1;
         if (ok) break;
      end
      req_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   typedef struct {
      logic        we;
      logic [3:0]  wmask;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [8];
   bit   ok;
   int   p0;

   initial begin
      tbl[0] = '{1'b1, 4'b1111, 8'h05, 32'hDEADBEEF, 32'h0};
      tbl[1] = '{1'b0, 4'b0000, 8'h05, 32'h0,        32'hDEADBEEF};
      tbl[2] = '{1'b1, 4'b0101, 8'h05, 32'h11223344, 32'h0};
      tbl[3] = '{1'b0, 4'b0000, 8'h05, 32'h0,        32'hDE22BE44};
      tbl[4] = '{1'b1, 4'b0000, 8'h05, 32'hFFFFFFFF, 32'h0};
      tbl[5] = '{1'b0, 4'b0000, 8'h05, 32'h0,        32'hDE22BE44};
      tbl[6] = '{1'b1, 4'b1111, 8'hFF, 32'hAA55AA55, 32'h0};
      tbl[7] = '{1'b0, 4'b0000, 8'hFF, 32'h0,        32'hAA55AA55};

      for (int i = 0; i < 256; i++) begin
         macro_mem[i] = 32'h0;
         ref_mem[i]   = 32'h0;
      end

      rst = 1'b1;
      req_valid = 1'b0;
      req_we = 1'b0;
      req_wmask = 4'h0;
      req_addr = 8'h0;
      req_wdata = 32'h0;
      rsp_ready = 1'b1;
      idle(2);
      @(negedge clk);
      chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("reset_req_ready", {31'b0, req_ready}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_reset_ready", {31'b0, req_ready}, 32'd1);
      @(posedge clk);
      #1;

      // Table: write/read pairs with explicit 2-edge latency check.
      foreach (tbl[i]) begin
         issue(tbl[i].we, tbl[i].wmask, tbl[i].addr, tbl[i].wdata, 20, ok);
         chk($sformatf("tbl%0d_accept", i), {31'b0, ok}, 32'd1);
         if (!tbl[i].we) begin
            @(negedge clk);
            chk($sformatf("tbl%0d_lat1", i), {31'b0, rsp_valid}, 32'd0);
            @(negedge clk);
            chk($sformatf("tbl%0d_lat2", i), {31'b0, rsp_valid}, 32'd1);
            chk($sformatf("tbl%0d_data", i), rsp_rdata, tbl[i].exp);
            @(posedge clk);
            #1;
         end
      end

      // Backpressure: two reads fill the credit, the third waits.
      rsp_ready = 1'b0;
      issue(1'b0, 4'h0, 8'h00, 32'h0, 1, ok);
      chk("bp_rd0_accept", {31'b0, ok}, 32'd1);
      issue(1'b0, 4'h0, 8'h01, 32'h0, 1, ok);
      chk("bp_rd1_accept", {31'b0, ok}, 32'd1);
      issue(1'b0, 4'h0, 8'h02, 32'h0, 4, ok);
      chk("bp_rd2_blocked", {31'b0, ok}, 32'd0);
      @(negedge clk);
      chk("bp_full_hold", {31'b0, rsp_valid}, 32'd1);
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      issue(1'b0, 4'h0, 8'h02, 32'h0, 4, ok);
      chk("bp_rd2_accept", {31'b0, ok}, 32'd1);
      idle(4);
      chk("bp_drained", exp_q.size(), 32'd0);

      // Preload 0x10..0x1F with addr*3, then stream reads.
      for (int a = 16; a < 32; a++) begin
         issue(1'b1, 4'hF, 8'(a), 32'(a * 3), 5, ok);
      end
      p0 = npop;
      for (int a = 16; a < 32; a++) begin
         issue(1'b0, 4'h0, 8'(a), 32'h0, 1, ok);
         chk($sformatf("b2b_accept_%0h", a), {31'b0, ok}, 32'd1);
      end
      idle(4);
      chk("b2b_count", 32'(npop - p0), 32'd16);

      // Read then write the same word on consecutive accepts.
      issue(1'b1, 4'hF, 8'h07, 32'h07070707, 5, ok);
      issue(1'b0, 4'h0, 8'h07, 32'h0, 5, ok);
      issue(1'b1, 4'hF, 8'h07, 32'hCAFEF00D, 1, ok);
      chk("rw_wr_accept", {31'b0, ok}, 32'd1);
      @(negedge clk);
      chk("rw_old_valid", {31'b0, rsp_valid}, 32'd1);
      chk("rw_old_data", rsp_rdata, 32'h07070707);
      chk("rw_no_x", {31'b0, $isunknown(rsp_rdata)}, 32'd0);
      @(posedge clk);
      #1;
      issue(1'b0, 4'h0, 8'h07, 32'h0, 5, ok);
      @(negedge clk);
      @(negedge clk);
      chk("rw_new_data", rsp_rdata, 32'hCAFEF00D);
      @(posedge clk);
      #1;

      // Reset with two responses queued; requests during reset refused.
      rsp_ready = 1'b0;
      issue(1'b0, 4'h0, 8'h10, 32'h0, 3, ok);
      issue(1'b0, 4'h0, 8'h11, 32'h0, 3, ok);
      idle(1);
      rst = 1'b1;
      req_valid = 1'b1;
      req_we = 1'b1;
      req_wmask = 4'hF;
      req_addr = 8'h10;
      req_wdata = 32'h0BAD0BAD;
      @(negedge clk);
      chk("rst6_queued", {31'b0, rsp_valid}, 32'd1);
      chk("rst6_ready", {31'b0, req_ready}, 32'd0);
      chk("rst6_we", {31'b0, sram_we}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      req_valid = 1'b0;
      @(negedge clk);
      chk("rst6_flushed", {31'b0, rsp_valid}, 32'd0);
      rsp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst6_no_stale", {31'b0, rsp_valid}, 32'd0);
      end
      @(posedge clk);
      #1;

      // Reset the cycle after a read accept drops the pending read.
      issue(1'b0, 4'h0, 8'h12, 32'h0, 3, ok);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rst_pend_no_stale", {31'b0, rsp_valid}, 32'd0);
      end
      @(posedge clk);
      #1;

      // Random traffic against the reference model.
      for (int i = 0; i < 600; i++) begin
         rst       = ($urandom_range(0, 99) == 0);
         req_valid = $urandom_range(0, 1);
         req_we    = ($urandom_range(0, 2) == 0);
         req_wmask = 4'($urandom);
         req_addr  = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
         req_wdata = $urandom;
         rsp_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      idle(6);
      chk("final_drain", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
